// File: rtl/hazard_forward_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_forward_ctrl_pkg
// Shared definitions for the hazard/forwarding controller:
//   - forward-select encodings (register file vs. pipeline stage k)
//   - scoreboard entry flag struct
//   - hardwired-zero register index
// ---------------------------------------------------------------------------
package hazard_forward_ctrl_pkg;

  // Forward select: FWD_RF reads the register file; stage k is encoded
  // as FWD_STAGE_BASE + k so that 0 stays reserved for "no forwarding".
  localparam int FWD_RF         = 0;
  localparam int FWD_STAGE_BASE = 1;

  // Register 0 is hardwired to zero and is never a forwarding target.
  localparam int REG_ZERO = 0;

  // Per-entry scoreboard flags. The destination address width is a module
  // parameter, so the rd field is stored in a parallel array beside these.
  typedef struct packed {
    logic valid;
    logic we;
    logic load;
  } sb_flags_t;

  // Forward-select code for a value sitting in scoreboard stage `stage`.
  function automatic int fwd_code(input int stage);
    return stage + FWD_STAGE_BASE;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_src_match.sv
// ---------------------------------------------------------------------------
// hazard_src_match
// Priority matcher for one source operand against the in-flight scoreboard.
// The youngest (lowest-index) matching stage wins.
//
// Ports:
//   i_src_addr  source register address
//   i_src_used  source is actually read by the instruction
//   i_sb_valid  per-stage entry valid
//   i_sb_we     per-stage entry writes the register file
//   i_sb_load   per-stage entry is a load
//   i_sb_rd     per-stage destination address
//   o_fwd_sel   0 = register file, k+1 = forward from stage k
//   o_load_hit  youngest match is a load whose data is not yet forwardable
// ---------------------------------------------------------------------------
module hazard_src_match
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic [REG_ADDR_W-1:0]                 i_src_addr,
  input  logic                                  i_src_used,
  input  logic [PIPE_DEPTH-1:0]                 i_sb_valid,
  input  logic [PIPE_DEPTH-1:0]                 i_sb_we,
  input  logic [PIPE_DEPTH-1:0]                 i_sb_load,
  input  logic [PIPE_DEPTH-1:0][REG_ADDR_W-1:0] i_sb_rd,
  output logic [SEL_W-1:0]                      o_fwd_sel,
  output logic                                  o_load_hit
);

  logic                  w_src_nonzero;
  logic [PIPE_DEPTH-1:0] w_match;

  assign w_src_nonzero = (i_src_addr != REG_ADDR_W'(REG_ZERO));

  always_comb begin
    w_match = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      w_match[k] = i_sb_valid[k] & i_sb_we[k] & i_src_used & w_src_nonzero &
                   (i_sb_rd[k] == i_src_addr);
    end
  end

  // Walk from oldest to youngest so the youngest match overwrites the rest.
  // The load-hit flag follows the winning stage only: an older non-load
  // producer behind a younger load does not hide the load.
  always_comb begin
    o_fwd_sel  = SEL_W'(FWD_RF);
    o_load_hit = 1'b0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        o_fwd_sel  = SEL_W'(fwd_code(k));
        o_load_hit = (k < LOAD_LAT) && i_sb_load[k];
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_forward_ctrl
// Forwarding and load-use hazard control for the instruction in ID.
// Destination registers of in-flight instructions are tracked in a
// PIPE_DEPTH-entry shift scoreboard (stage 0 = EXE). Per-source forward
// selects and the stall are combinational from the ID inputs; the
// scoreboard shifts every cycle and receives a bubble on stall, flush or
// an empty ID slot.
//
// Ports:
//   Clock_in          core clock, rising edge
//   Reset_in          asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_src_addr       source addresses, source i at [i*REG_ADDR_W +: REG_ADDR_W]
//   id_src_used       source i is actually read
//   id_rd_addr        destination address
//   id_rd_we          instruction writes the register file
//   id_is_load        instruction is a memory load
//   flush_in          branch taken in EXE; kill the instruction in ID
//   stall_out         hold PC and IF/ID, bubble into EXE
//   fwd_sel_out       per source: 0 = register file, k = value from stage k-1
//   inflight_cnt_out  number of valid scoreboard entries
//
// Optional (macro HAZARD_FWD_STATS_EN):
//   stall_cnt_out     saturating count of stalled cycles
//   fwd_cnt_out       saturating count of issued instructions using forwarding
// ---------------------------------------------------------------------------
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                          Clock_in,
  input  logic                          Reset_in,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_rd_addr,
  input  logic                          id_rd_we,
  input  logic                          id_is_load,
  input  logic                          flush_in,
  output logic                          stall_out,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_out,
  output logic [SEL_W-1:0]              inflight_cnt_out
`ifdef HAZARD_FWD_STATS_EN
  ,
  output logic [31:0]                   stall_cnt_out,
  output logic [31:0]                   fwd_cnt_out
`endif
);

  sb_flags_t [PIPE_DEPTH-1:0]           r_sb_flags;
  logic [PIPE_DEPTH-1:0][REG_ADDR_W-1:0] r_sb_rd;
  logic [SEL_W-1:0]                      r_inflight_cnt;

  logic [PIPE_DEPTH-1:0]  w_sb_valid;
  logic [PIPE_DEPTH-1:0]  w_sb_we;
  logic [PIPE_DEPTH-1:0]  w_sb_load;
  logic [NUM_SRC-1:0]     w_load_hit;
  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic                   w_stall;
  logic                   w_push;
  sb_flags_t              w_new_flags;
  logic [PIPE_DEPTH-1:0]  w_next_valid;
  logic [SEL_W-1:0]       w_next_cnt;

  always_comb begin
    w_sb_valid = '0;
    w_sb_we    = '0;
    w_sb_load  = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      w_sb_valid[k] = r_sb_flags[k].valid;
      w_sb_we[k]    = r_sb_flags[k].we;
      w_sb_load[k]  = r_sb_flags[k].load;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hazard_src_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .PIPE_DEPTH (PIPE_DEPTH),
      .LOAD_LAT   (LOAD_LAT),
      .SEL_W      (SEL_W)
    ) u_match (
      .i_src_addr (id_src_addr[s*REG_ADDR_W +: REG_ADDR_W]),
      .i_src_used (id_src_used[s]),
      .i_sb_valid (w_sb_valid),
      .i_sb_we    (w_sb_we),
      .i_sb_load  (w_sb_load),
      .i_sb_rd    (r_sb_rd),
      .o_fwd_sel  (w_fwd_sel[s*SEL_W +: SEL_W]),
      .o_load_hit (w_load_hit[s])
    );
  end

  // Flush has priority over a hazard: the instruction is dying anyway.
  assign w_stall = id_valid & ~flush_in & (|w_load_hit);
  assign w_push  = id_valid & ~flush_in & ~w_stall;

  always_comb begin
    w_new_flags       = '0;
    w_new_flags.valid = 1'b1;
    w_new_flags.we    = id_rd_we;
    w_new_flags.load  = id_is_load;
  end

  // Occupancy after the coming edge, so the registered count matches the
  // scoreboard contents it is sampled alongside.
  always_comb begin
    w_next_valid    = '0;
    w_next_valid[0] = w_push;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      w_next_valid[k] = w_sb_valid[k-1];
    end
    w_next_cnt = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      w_next_cnt = w_next_cnt + SEL_W'(w_next_valid[k]);
    end
  end

  // Scoreboard shift: never stalls; only ID is held.
  always_ff @(posedge Clock_in or negedge Reset_in) begin
    if (!Reset_in) begin
      r_sb_flags     <= '0;
      r_sb_rd        <= '0;
      r_inflight_cnt <= '0;
    end else begin
      for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
        r_sb_flags[k] <= r_sb_flags[k-1];
        r_sb_rd[k]    <= r_sb_rd[k-1];
      end
      if (w_push) begin
        r_sb_flags[0] <= w_new_flags;
        r_sb_rd[0]    <= id_rd_addr;
      end else begin
        r_sb_flags[0] <= '0;
        r_sb_rd[0]    <= '0;
      end
      r_inflight_cnt <= w_next_cnt;
    end
  end

  assign stall_out        = w_stall;
  assign fwd_sel_out      = w_fwd_sel;
  assign inflight_cnt_out = r_inflight_cnt;

`ifdef HAZARD_FWD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;
  logic        w_fwd_used;

  assign w_fwd_used = w_push & (|w_fwd_sel);

  // Both counters saturate rather than wrap.
  always_ff @(posedge Clock_in or negedge Reset_in) begin
    if (!Reset_in) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_fwd_used && (r_fwd_cnt != 32'hFFFF_FFFF)) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_out = r_stall_cnt;
  assign fwd_cnt_out   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

  localparam int RW = 4;
  localparam int NS = 2;
  localparam int PD = 3;
  localparam int LL = 1;
  localparam int SW = $clog2(PD + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               id_valid;
  logic [NS*RW-1:0]   id_src_addr;
  logic [NS-1:0]      id_src_used;
  logic [RW-1:0]      id_rd_addr;
  logic               id_rd_we;
  logic               id_is_load;
  logic               flush_in;
  logic               stall_out;
  logic [NS*SW-1:0]   fwd_sel_out;
  logic [SW-1:0]      inflight_cnt_out;
`ifdef HAZARD_FWD_STATS_EN
  logic [31:0]        stall_cnt_out;
  logic [31:0]        fwd_cnt_out;
`endif

  hazard_forward_ctrl #(
    .REG_ADDR_W (RW),
    .NUM_SRC    (NS),
    .PIPE_DEPTH (PD),
    .LOAD_LAT   (LL)
  ) dut (
    .Clock_in         (clk),
    .Reset_in         (rst_n),
    .id_valid         (id_valid),
    .id_src_addr      (id_src_addr),
    .id_src_used      (id_src_used),
    .id_rd_addr       (id_rd_addr),
    .id_rd_we         (id_rd_we),
    .id_is_load       (id_is_load),
    .flush_in         (flush_in),
    .stall_out        (stall_out),
    .fwd_sel_out      (fwd_sel_out),
    .inflight_cnt_out (inflight_cnt_out)
`ifdef HAZARD_FWD_STATS_EN
    ,
    .stall_cnt_out    (stall_cnt_out),
    .fwd_cnt_out      (fwd_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                       input logic [1:0] used, input logic [RW-1:0] rd, input logic we,
                       input logic ld, input logic fl);
    id_valid    = vld;
    id_src_addr = {s1, s0};
    id_src_used = used;
    id_rd_addr  = rd;
    id_rd_we    = we;
    id_is_load  = ld;
    flush_in    = fl;
  endtask

  function automatic logic [SW-1:0] sel_of(input int s);
    logic [NS*SW-1:0] f;
    f = fwd_sel_out;
    return f[s*SW +: SW];
  endfunction

  typedef struct {
    logic          vld;
    logic [RW-1:0] s0;
    logic [RW-1:0] s1;
    logic [1:0]    used;
    logic [RW-1:0] rd;
    logic          we;
    logic          ld;
    logic          fl;
    logic          chk_sel;
    logic          stall;
    int            sel0;
    int            sel1;
    int            cnt;
  } vec_t;

  function automatic vec_t mkv(input logic vld, input int s0, input int s1, input int used,
                               input int rd, input logic we, input logic ld, input logic fl,
                               input logic chk, input logic st, input int e0, input int e1,
                               input int cnt);
    vec_t v;
    v.vld = vld; v.s0 = RW'(s0); v.s1 = RW'(s1); v.used = 2'(used);
    v.rd = RW'(rd); v.we = we; v.ld = ld; v.fl = fl; v.chk_sel = chk;
    v.stall = st; v.sel0 = e0; v.sel1 = e1; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl[14];

  // Reference model: a list of in-flight instructions, youngest first.
  logic       m_v  [PD];
  logic [RW-1:0] m_rd [PD];
  logic       m_we [PD];
  logic       m_ld [PD];
  longint     e_stall_cnt;
  longint     e_fwd_cnt;

  function automatic int model_sel(input logic [RW-1:0] src, input logic used);
    if (!used || src == 0) return 0;
    for (int k = 0; k < PD; k++) begin
      if (m_v[k] && m_we[k] && m_rd[k] == src) return k + 1;
    end
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < PD; k++) begin
      m_v[k] = 1'b0; m_rd[k] = '0; m_we[k] = 1'b0; m_ld[k] = 1'b0;
    end
    e_stall_cnt = 0;
    e_fwd_cnt   = 0;
  endtask

  initial begin
    int r_sel[NS];
    logic [RW-1:0] srcs[NS];
    logic hz, e_stall, push;
    int cnt;

    tbl[0]  = mkv(1, 1, 2, 3, 3, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mkv(1, 3, 0, 3, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    tbl[2]  = mkv(1, 3, 7, 1, 5, 1, 1, 0, 1, 0, 2, 0, 2);
    tbl[3]  = mkv(1, 5, 4, 3, 6, 1, 0, 0, 1, 1, 1, 0, 3);
    tbl[4]  = mkv(1, 5, 4, 3, 6, 1, 0, 0, 1, 0, 2, 0, 2);
    tbl[5]  = mkv(1, 6, 0, 1, 2, 1, 0, 0, 1, 0, 1, 0, 2);
    tbl[6]  = mkv(1, 0, 0, 0, 9, 1, 0, 0, 1, 0, 0, 0, 2);
    tbl[7]  = mkv(1, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0, 0, 3);
    tbl[8]  = mkv(1, 2, 9, 3, 0, 1, 0, 0, 1, 0, 1, 2, 3);
    tbl[9]  = mkv(1, 0, 2, 1, 7, 1, 1, 0, 1, 0, 0, 0, 3);
    tbl[10] = mkv(1, 7, 0, 1, 8, 1, 0, 1, 1, 0, 1, 0, 3);
    tbl[11] = mkv(1, 8, 7, 3, 0, 0, 0, 0, 1, 0, 0, 2, 2);
    tbl[12] = mkv(0, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 2);
    tbl[13] = mkv(1, 5, 7, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.stall", 32'(stall_out), 0);
    check("reset.fwd", 32'(fwd_sel_out), 0);
    check("reset.cnt", 32'(inflight_cnt_out), 0);
`ifdef HAZARD_FWD_STATS_EN
    check("reset.stall_cnt", stall_cnt_out, 0);
    check("reset.fwd_cnt", fwd_cnt_out, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].vld, tbl[i].s0, tbl[i].s1, tbl[i].used, tbl[i].rd,
            tbl[i].we, tbl[i].ld, tbl[i].fl);
      #1;
      check($sformatf("tbl%0d.stall", i), 32'(stall_out), 32'(tbl[i].stall));
      check($sformatf("tbl%0d.cnt", i), 32'(inflight_cnt_out), 32'(tbl[i].cnt));
      if (tbl[i].chk_sel) begin
        check($sformatf("tbl%0d.sel0", i), 32'(sel_of(0)), 32'(tbl[i].sel0));
        check($sformatf("tbl%0d.sel1", i), 32'(sel_of(1)), 32'(tbl[i].sel1));
      end
    end

    // Load-use from a clean reset: one stall cycle, then forward from MEM.
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 0, 0, 0, 5, 1, 1, 0);
    @(negedge clk);
    drive(1, 5, 0, 1, 6, 1, 0, 0);
    #1;
    check("lu.stall", 32'(stall_out), 1);
    check("lu.sel_exe", 32'(sel_of(0)), 1);
    @(negedge clk);
    #1;
    check("lu.release", 32'(stall_out), 0);
    check("lu.sel_mem", 32'(sel_of(0)), 2);
    check("lu.cnt", 32'(inflight_cnt_out), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("lu.cnt_after", 32'(inflight_cnt_out), 2);
`ifdef HAZARD_FWD_STATS_EN
    check("lu.stall_cnt", stall_cnt_out, 1);
    check("lu.fwd_cnt", fwd_cnt_out, 1);
`endif

    // Reset asserted in the middle of a stall.
    @(negedge clk);
    drive(1, 0, 0, 0, 5, 1, 1, 0);
    @(negedge clk);
    drive(1, 0, 5, 2, 6, 1, 0, 0);
    #1;
    check("rms.stall_before", 32'(stall_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rms.stall", 32'(stall_out), 0);
    check("rms.cnt", 32'(inflight_cnt_out), 0);
    check("rms.fwd", 32'(fwd_sel_out), 0);
`ifdef HAZARD_FWD_STATS_EN
    check("rms.stall_cnt", stall_cnt_out, 0);
    check("rms.fwd_cnt", fwd_cnt_out, 0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    model_clear();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      srcs[0] = RW'($urandom_range(0, 3));
      srcs[1] = RW'($urandom_range(0, 3));
      drive(($urandom % 4) != 0, srcs[0], srcs[1], 2'($urandom_range(0, 3)),
            RW'($urandom_range(0, 3)), ($urandom % 4) != 0, ($urandom % 3) == 0,
            ($urandom % 8) == 0);
      #1;
      hz = 1'b0;
      for (int s = 0; s < NS; s++) begin
        r_sel[s] = model_sel(srcs[s], id_src_used[s]);
        if (r_sel[s] != 0 && (r_sel[s] - 1) < LL && m_ld[r_sel[s] - 1]) hz = 1'b1;
      end
      e_stall = id_valid && !flush_in && hz;
      push    = id_valid && !flush_in && !e_stall;
      cnt = 0;
      for (int k = 0; k < PD; k++) if (m_v[k]) cnt++;
      check($sformatf("rnd%0d.stall", c), 32'(stall_out), 32'(e_stall));
      check($sformatf("rnd%0d.cnt", c), 32'(inflight_cnt_out), 32'(cnt));
      if (id_valid) begin
        check($sformatf("rnd%0d.sel0", c), 32'(sel_of(0)), 32'(r_sel[0]));
        check($sformatf("rnd%0d.sel1", c), 32'(sel_of(1)), 32'(r_sel[1]));
      end
`ifdef HAZARD_FWD_STATS_EN
      check($sformatf("rnd%0d.stall_cnt", c), stall_cnt_out, 32'(e_stall_cnt));
      check($sformatf("rnd%0d.fwd_cnt", c), fwd_cnt_out, 32'(e_fwd_cnt));
`endif
      if (e_stall) e_stall_cnt++;
      if (push && (r_sel[0] != 0 || r_sel[1] != 0)) e_fwd_cnt++;
      for (int k = PD - 1; k >= 1; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1];
      end
      m_v[0]  = push;
      m_rd[0] = push ? id_rd_addr : '0;
      m_we[0] = push ? id_rd_we : 1'b0;
      m_ld[0] = push ? id_is_load : 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
